// File: rtl/ahb_master_seq_gen.sv
// ahb_master_seq_gen: run-time programmable AHB master step sequencer.
// Plays a DEPTH-entry table onto the master interface and counts errors.
module ahb_master_seq_gen #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SLV_W       = 2,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 64,
  parameter int ERR_W       = 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [SLV_W-1:0]  prog_slv,
  input  logic              prog_wr,
  input  logic              prog_chk,
  input  logic [IDX_W:0]    num_steps,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  input  logic              hgrant,
  input  logic              done,
  input  logic [DATA_W-1:0] dout,
  input  logic              hresp,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic [SLV_W-1:0]  slv_sel_in,
  output logic              wr,
  output logic              enable,
  output logic              hbusreq_in,
  output logic              busy,
  output logic [IDX_W-1:0]  step_idx,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              seq_done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  localparam logic [HW-1:0] H_LAST =
    HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [IDX_W:0] N_MAX = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_ISSUE, S_HOLD
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] t_addr [DEPTH];
  logic [DATA_W-1:0] t_data [DEPTH];
  logic [SLV_W-1:0]  t_slv  [DEPTH];
  logic              t_wr   [DEPTH];
  logic              t_chk  [DEPTH];

  logic              cur_chk, chk_n;
  logic [DATA_W-1:0] cur_exp, exp_n;
  logic [IDX_W-1:0]  last_idx, last_n;
  logic              loop_q, loop_n;
  logic [TW-1:0]     wcnt, wcnt_n;
  logic [HW-1:0]     hcnt, hcnt_n;

  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n;
  logic [SLV_W-1:0]  slv_n;
  logic              wr_n, en_n, req_n, busy_n, sd_n;
  logic [IDX_W-1:0]  idx_n;
  logic [ERR_W-1:0]  err_n;

  logic [IDX_W-1:0]  ld_idx;
  logic              byp;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic [SLV_W-1:0]  e_slv;
  logic              e_wr, e_chk;
  logic              ns_ok, tmo;
  logic              fin, bump, adv, load, stop;

  // Table write port; frozen while a sequence is playing.
  always_ff @(posedge hclk) begin
    if (prog_we && state == S_IDLE) begin
      t_addr[prog_idx] <= prog_addr;
      t_data[prog_idx] <= prog_data;
      t_slv[prog_idx]  <= prog_slv;
      t_wr[prog_idx]   <= prog_wr;
      t_chk[prog_idx]  <= prog_chk;
    end
  end

  // Next entry fetch, forwarding a same-cycle write at start.
  always_comb begin
    ld_idx = (state == S_IDLE || step_idx == last_idx)
           ? '0 : step_idx + 1'b1;
    byp    = prog_we && state == S_IDLE && prog_idx == ld_idx;
    e_addr = byp ? prog_addr : t_addr[ld_idx];
    e_data = byp ? prog_data : t_data[ld_idx];
    e_slv  = byp ? prog_slv  : t_slv[ld_idx];
    e_wr   = byp ? prog_wr   : t_wr[ld_idx];
    e_chk  = byp ? prog_chk  : t_chk[ld_idx];
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    din_n   = din;
    slv_n   = slv_sel_in;
    wr_n    = wr;
    en_n    = enable;
    req_n   = hbusreq_in;
    busy_n  = busy;
    idx_n   = step_idx;
    err_n   = err_cnt;
    sd_n    = 1'b0;
    chk_n   = cur_chk;
    exp_n   = cur_exp;
    last_n  = last_idx;
    loop_n  = loop_q;
    wcnt_n  = wcnt;
    hcnt_n  = hcnt;
    fin     = 1'b0;
    bump    = 1'b0;
    adv     = 1'b0;
    load    = 1'b0;
    stop    = 1'b0;
    ns_ok   = num_steps != '0 && num_steps <= N_MAX;
    tmo     = wcnt >= T_LAST;
    unique case (state)
      S_IDLE: begin
        if (start && ns_ok) begin
          load   = 1'b1;
          err_n  = '0;
          busy_n = 1'b1;
          last_n = IDX_W'(num_steps - 1'b1);
          loop_n = loop_en;
        end
      end
      S_REQ: begin
        if (abort) begin
          stop = 1'b1;
        end else if (hgrant) begin
          en_n    = 1'b1;
          state_n = S_ISSUE;
        end else if (tmo) begin
          fin  = 1'b1;
          bump = 1'b1;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          stop = 1'b1;
        end else if (done) begin
          fin  = 1'b1;
          bump = hresp ||
                 (!wr && cur_chk && dout != cur_exp);
        end else if (tmo) begin
          fin  = 1'b1;
          bump = 1'b1;
        end
      end
      S_HOLD: begin
        if (abort) begin
          stop = 1'b1;
        end else if (hcnt == H_LAST) begin
          adv = 1'b1;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if ((state == S_REQ || state == S_ISSUE) && wcnt != T_MAX)
      wcnt_n = wcnt + 1'b1;
    if (bump && err_cnt != '1)
      err_n = err_cnt + 1'b1;
    if (fin) begin
      en_n = 1'b0;
      if (HOLD_CYCLES == 0) begin
        adv = 1'b1;
      end else begin
        state_n = S_HOLD;
        req_n   = 1'b0;
        hcnt_n  = '0;
      end
    end
    if (adv) begin
      if (step_idx != last_idx || loop_q) begin
        load = 1'b1;
      end else begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        req_n   = 1'b0;
        sd_n    = 1'b1;
      end
    end
    if (load) begin
      state_n = S_REQ;
      req_n   = 1'b1;
      idx_n   = ld_idx;
      addr_n  = e_addr;
      din_n   = e_wr ? e_data : '0;
      slv_n   = e_slv;
      wr_n    = e_wr;
      chk_n   = e_chk;
      exp_n   = e_data;
      wcnt_n  = '0;
    end
    if (stop) begin
      state_n = S_IDLE;
      en_n    = 1'b0;
      req_n   = 1'b0;
      busy_n  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= S_IDLE;
      addr       <= '0;
      din        <= '0;
      slv_sel_in <= '0;
      wr         <= 1'b0;
      enable     <= 1'b0;
      hbusreq_in <= 1'b0;
      busy       <= 1'b0;
      step_idx   <= '0;
      err_cnt    <= '0;
      seq_done   <= 1'b0;
      cur_chk    <= 1'b0;
      cur_exp    <= '0;
      last_idx   <= '0;
      loop_q     <= 1'b0;
      wcnt       <= '0;
      hcnt       <= '0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      din        <= din_n;
      slv_sel_in <= slv_n;
      wr         <= wr_n;
      enable     <= en_n;
      hbusreq_in <= req_n;
      busy       <= busy_n;
      step_idx   <= idx_n;
      err_cnt    <= err_n;
      seq_done   <= sd_n;
      cur_chk    <= chk_n;
      cur_exp    <= exp_n;
      last_idx   <= last_n;
      loop_q     <= loop_n;
      wcnt       <= wcnt_n;
      hcnt       <= hcnt_n;
    end
  end

endmodule

// File: tb/tb_ahb_master_seq_gen.sv
// tb_ahb_master_seq_gen: randomized step-level model bench for the
// programmable AHB master sequencer.
module tb_ahb_master_seq_gen;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int DEPTH = 16;
  localparam int IW = 4;
  localparam int EW = 8;

  logic hclk = 1'b0;
  logic hreset;
  logic prog_we;
  logic [IW-1:0] prog_idx;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [SW-1:0] prog_slv;
  logic prog_wr, prog_chk;
  logic [IW:0] num_steps;
  logic loop_en, start, abort, hgrant, done, hresp;
  logic [DW-1:0] dout;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [SW-1:0] slv_sel_in;
  logic wr, enable, hbusreq_in, busy, seq_done;
  logic [IW-1:0] step_idx;
  logic [EW-1:0] err_cnt;

  always #5 hclk = ~hclk;

  ahb_master_seq_gen dut (
    .hclk(hclk), .hreset(hreset),
    .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_slv(prog_slv), .prog_wr(prog_wr),
    .prog_chk(prog_chk), .num_steps(num_steps),
    .loop_en(loop_en), .start(start), .abort(abort),
    .hgrant(hgrant), .done(done), .dout(dout),
    .hresp(hresp), .addr(addr), .din(din),
    .slv_sel_in(slv_sel_in), .wr(wr), .enable(enable),
    .hbusreq_in(hbusreq_in), .busy(busy),
    .step_idx(step_idx), .err_cnt(err_cnt),
    .seq_done(seq_done)
  );

  logic [AW-1:0] m_addr [DEPTH];
  logic [DW-1:0] m_data [DEPTH];
  logic [SW-1:0] m_slv  [DEPTH];
  logic          m_wr   [DEPTH];
  logic          m_chk  [DEPTH];
  int m_step, m_n, m_err;
  bit m_loop, m_busy, m_end, chk_en;
  int total = 0;
  int bad = 0;
  int sd_cnt = 0;
  int en_rise = 0;
  logic en_q = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (seq_done === 1'b1) sd_cnt++;
    if (enable === 1'b1 && en_q !== 1'b1) en_rise++;
    en_q = enable;
  end

  // Whenever a request is up, the bus fields must show the model's step.
  always @(negedge hclk) begin
    if (chk_en && hbusreq_in === 1'b1) begin
      chk("cyc_step", step_idx, m_step);
      chk("cyc_addr", addr, m_addr[m_step]);
      chk("cyc_din", din, m_wr[m_step] ? m_data[m_step] : 0);
      chk("cyc_slv", slv_sel_in, m_slv[m_step]);
      chk("cyc_wr", wr, m_wr[m_step]);
      chk("cyc_busy", busy, 1);
      chk("cyc_err", err_cnt, m_err);
    end
    if (chk_en && busy === 1'b0) begin
      chk("idle_en", enable, 0);
      chk("idle_req", hbusreq_in, 0);
    end
  end

  task automatic m_write(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic w, input logic c);
    if (!m_busy) begin
      m_addr[i] = a; m_data[i] = d; m_slv[i] = s;
      m_wr[i] = w; m_chk[i] = c;
    end
  endtask

  task automatic prog(input int i, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s,
                      input logic w, input logic c);
    prog_idx = IW'(i); prog_addr = a; prog_data = d;
    prog_slv = s; prog_wr = w; prog_chk = c; prog_we = 1'b1;
    m_write(i, a, d, s, w, c);
    @(posedge hclk); #1;
    prog_we = 1'b0;
  endtask

  task automatic prog_rand(input int i);
    prog(i, $urandom, $urandom, SW'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic start_seq(input int n, input bit lp);
    num_steps = 5'(n); loop_en = lp; start = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0; prog_we = 1'b0;
    m_n = n; m_loop = lp; m_step = 0; m_err = 0;
    m_end = 0; m_busy = 1;
    chk("start_busy", busy, 1);
  endtask

  // mode 0: random grant/done/response, 1: fixed response, 2: no grant
  task automatic do_step(input int mode, input logic [DW-1:0] fd,
                         input bit fh);
    int gd, dd, s;
    bit hr, e;
    logic [DW-1:0] dv;
    s = m_step;
    if (mode == 2) begin
      hgrant = 1'b0;
      repeat (63) @(posedge hclk);
      #1;
      chk("tmo_wait", hbusreq_in, 1);
      @(posedge hclk); #1;
      chk("tmo_fire", hbusreq_in, 0);
      e = 1;
    end else begin
      gd = (mode == 0) ? $urandom_range(0, 3) : 0;
      repeat (gd) begin @(posedge hclk); #1; end
      hgrant = 1'b1;
      @(posedge hclk); #1;
      hgrant = 1'b0;
      chk("grant_en", enable, 1);
      dd = (mode == 0) ? $urandom_range(0, 3) : 0;
      repeat (dd) begin @(posedge hclk); #1; end
      if (mode == 0) begin
        hr = $urandom_range(0, 7) == 0;
        dv = $urandom_range(0, 1) ? m_data[s] : $urandom;
      end else begin
        hr = fh && !m_wr[s];
        dv = fd;
      end
      done = 1'b1; dout = dv; hresp = hr;
      @(posedge hclk); #1;
      done = 1'b0; dout = '0; hresp = 1'b0;
      chk("done_en", enable, 0);
      e = hr || (!m_wr[s] && m_chk[s] && dv != m_data[s]);
    end
    if (e && m_err < 255) m_err++;
    if (m_step == m_n - 1) begin
      if (m_loop) m_step = 0;
      else m_end = 1;
    end else begin
      m_step++;
    end
  endtask

  task automatic gap_check();
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    chk("hold_req_low", hbusreq_in, 0);
    @(posedge hclk); #1;
    chk("next_req", hbusreq_in, 1);
  endtask

  task automatic end_check();
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    chk("end_sd_early", seq_done, 0);
    @(posedge hclk); #1;
    chk("end_sd", seq_done, 1);
    chk("end_busy", busy, 0);
    m_busy = 0;
    @(posedge hclk); #1;
    chk("end_sd_pulse", seq_done, 0);
  endtask

  task automatic play(input int steps, input int mode,
                      input logic [DW-1:0] fd, input bit fh);
    for (int k = 0; k < steps; k++) begin
      do_step(mode, fd, fh);
      if (m_end) begin
        end_check();
        break;
      end
      gap_check();
    end
  endtask

  task automatic run_seq(input int n, input bit lp, input int steps,
                         input int mode, input logic [DW-1:0] fd,
                         input bit fh);
    start_seq(n, lp);
    play(steps, mode, fd, fh);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge hclk); #1;
    abort = 1'b0;
    m_busy = 0;
    chk("abort_busy", busy, 0);
    chk("abort_req", hbusreq_in, 0);
  endtask

  task automatic bad_start(input int n);
    num_steps = 5'(n); loop_en = 1'b0; start = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0;
    chk("badn_busy", busy, 0);
    chk("badn_req", hbusreq_in, 0);
    @(posedge hclk); #1;
    chk("badn_busy2", busy, 0);
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_addr"}, addr, 0);
    chk({nm, "_din"}, din, 0);
    chk({nm, "_slv"}, slv_sel_in, 0);
    chk({nm, "_wr"}, wr, 0);
    chk({nm, "_en"}, enable, 0);
    chk({nm, "_req"}, hbusreq_in, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_idx"}, step_idx, 0);
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_sd"}, seq_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s0, n;
    hreset = 1'b1; prog_we = 1'b0; prog_idx = '0;
    prog_addr = '0; prog_data = '0; prog_slv = '0;
    prog_wr = 1'b0; prog_chk = 1'b0; num_steps = '0;
    loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    hgrant = 1'b0; done = 1'b0; dout = '0; hresp = 1'b0;
    m_busy = 0; m_step = 0; m_n = 1; m_err = 0; chk_en = 0;
    for (int i = 0; i < DEPTH; i++) m_write(i, 0, 0, 0, 0, 0);
    repeat (3) @(posedge hclk);
    #1;
    zero_check("rst");
    hreset = 1'b0;
    chk_en = 1;
    for (int i = 0; i < DEPTH; i++) prog_rand(i);

    prog(0, 2, 6, 0, 1, 0);
    prog(1, 2, 6, 0, 0, 1);
    e0 = en_rise;
    run_seq(2, 0, 2, 1, 6, 0);
    chk("rt_err", err_cnt, 0);
    chk("rt_en_pulses", en_rise - e0, 2);
    run_seq(2, 0, 2, 1, 5, 0);
    chk("cmp_err", err_cnt, 1);
    run_seq(2, 0, 2, 1, 5, 1);
    chk("cmp_resp_err", err_cnt, 1);
    run_seq(2, 0, 2, 2, 0, 0);
    chk("tmo_err", err_cnt, 2);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) prog_rand($urandom_range(0, 15));
      n = $urandom_range(1, 16);
      run_seq(n, 0, n, 0, 0, 0);
      chk("rand_err", err_cnt, m_err);
    end

    s0 = sd_cnt;
    run_seq(16, 0, 16, 0, 0, 0);
    chk("full_sd", sd_cnt - s0, 1);
    chk("full_err", err_cnt, m_err);

    s0 = sd_cnt;
    run_seq(3, 1, 7, 0, 0, 0);
    chk("loop_no_sd", sd_cnt - s0, 0);
    chk("loop_busy", busy, 1);
    chk("loop_idx", step_idx, 1);
    hgrant = 1'b1;
    @(posedge hclk); #1;
    hgrant = 1'b0;
    chk("abort_issue_en", enable, 1);
    abort = 1'b1; done = 1'b1; hresp = 1'b1;
    @(posedge hclk); #1;
    abort = 1'b0; done = 1'b0; hresp = 1'b0;
    m_busy = 0;
    chk("abort_busy", busy, 0);
    chk("abort_req", hbusreq_in, 0);
    chk("abort_en", enable, 0);
    chk("abort_err", err_cnt, m_err);
    chk("abort_sd", seq_done, 0);
    chk("abort_no_sd", sd_cnt - s0, 0);

    bad_start(0);
    bad_start(DEPTH + 1);

    prog_idx = '0; prog_addr = 'hE0; prog_data = 'h77;
    prog_slv = 2; prog_wr = 1'b1; prog_chk = 1'b0; prog_we = 1'b1;
    m_write(0, 'hE0, 'h77, 2, 1, 0);
    start_seq(3, 0);
    chk("sim_addr", addr, 'hE0);
    chk("sim_din", din, 'h77);
    play(3, 0, 0, 0);

    prog(0, 'hA0, 'hA5A5, 1, 1, 0);
    prog(1, 'hB0, 'h0, 2, 0, 0);
    start_seq(2, 0);
    prog(0, 'hC0, 'hDEAD, 3, 0, 1);
    play(2, 0, 0, 0);
    start_seq(2, 0);
    chk("replay_addr", addr, 'hA0);
    chk("replay_slv", slv_sel_in, 1);
    play(2, 0, 0, 0);

    prog(0, 'h40, 'h1234, 1, 0, 1);
    start_seq(2, 0);
    do_step(1, 'h99, 0);
    chk("pre_rst_err", err_cnt, 1);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    m_busy = 0;
    zero_check("hold_rst");
    hreset = 1'b0;

    prog(0, 'h10, 0, 0, 0, 0);
    prog(1, 'h14, 0, 1, 0, 0);
    run_seq(2, 1, 260, 1, 0, 1);
    chk("sat_err", err_cnt, 255);
    do_abort();
    chk("sat_err_kept", err_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
